led_mode_controller: RTL and testbench

//  Downstream stage of the blink generator: consumes its four rate outputs
//  (10/5/2/1 Hz) and drives the four board LEDs.
//  A debounced push button cycles the LED display through four modes:

---
 rtl/led_ctrl_pkg.sv | 26 ++
 rtl/switch_debounce.sv | 50 +++++
 rtl/led_mode_controller.sv | 90 +++++++++
 tb/tb_led_mode_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared mode encoding and blink-rate bit positions for the LED controller
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_DIM   = 2'd3
  } mode_t;

  localparam int BLINK_10HZ = 0;
  localparam int BLINK_5HZ  = 1;
  localparam int BLINK_2HZ  = 2;
  localparam int BLINK_1HZ  = 3;

  // Mode sequence advanced by each button press, wrapping DIM back to PASS
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_PASS:  next_mode = MODE_ALL;
      MODE_ALL:   next_mode = MODE_CHASE;
      MODE_CHASE: next_mode = MODE_DIM;
      default:    next_mode = MODE_PASS;
    endcase
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - push-button synchronizer, debounce counter and press pulse
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_Sw,
  output logic o_State,
  output logic o_Press
);

  // Counter only has to hold 0..DEBOUNCE_LIMIT-1; the flip happens on the
  // cycle it would have reached DEBOUNCE_LIMIT.
  localparam int CW = (DEBOUNCE_LIMIT < 2) ? 1 : $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          state;
  logic          state_d;

  // Synchronize the raw button, debounce it, and pulse once on each 0->1 flip
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      state   <= 1'b0;
      state_d <= 1'b0;
      o_Press <= 1'b0;
    end else begin
      sync1   <= i_Sw;
      sync2   <= sync1;
      state_d <= state;
      o_Press <= state & ~state_d;
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_State = state;

endmodule

// File: rtl/led_mode_controller.sv
// rtl/led_mode_controller.sv - button-selected LED display modes driven from the blink generator rates
module led_mode_controller
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int PWM_BITS       = 4,
  parameter int DIM_DUTY       = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW,
  input  logic [3:0] BLINK_IN,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic [1:0] MODE
);

  logic                sw_state;
  logic                sw_press;
  logic                press;
  mode_t               mode;
  logic [1:0]          pos;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                blink5_d;
  logic                blink5_rise;
  logic [3:0]          led_next;
  logic [3:0]          led_q;

  switch_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce (
    .CLK    (CLK),
    .RST    (RST),
    .i_Sw   (SW),
    .o_State(sw_state),
    .o_Press(sw_press)
  );

  // The press pulse always follows the debounced state going high, so
  // qualifying with it keeps any stray pulse from advancing the mode.
  assign press       = sw_press & sw_state;
  assign blink5_rise = BLINK_IN[BLINK_5HZ] & ~blink5_d;

  // Select the LED pattern for the current mode
  always_comb begin
    led_next = 4'b0000;
    case (mode)
      MODE_PASS: begin
        led_next[0] = BLINK_IN[BLINK_10HZ];
        led_next[1] = BLINK_IN[BLINK_5HZ];
        led_next[2] = BLINK_IN[BLINK_2HZ];
        led_next[3] = BLINK_IN[BLINK_1HZ];
      end
      MODE_ALL:   led_next = {4{BLINK_IN[BLINK_1HZ]}};
      MODE_CHASE: led_next = 4'b0001 << pos;
      MODE_DIM:   led_next = {4{pwm_cnt < PWM_BITS'(DIM_DUTY)}};
      default:    led_next = 4'b0000;
    endcase
  end

  // Mode FSM, chase position, free-running PWM and registered LED drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode     <= MODE_PASS;
      pos      <= 2'd0;
      pwm_cnt  <= '0;
      blink5_d <= 1'b0;
      led_q    <= 4'b0000;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      blink5_d <= BLINK_IN[BLINK_5HZ];
      led_q    <= led_next;
      if (press) begin
        mode <= next_mode(mode);
        pos  <= 2'd0;
      end else if (blink5_rise) begin
        pos <= pos + 2'd1;
      end
    end
  end

  assign LED1 = led_q[0];
  assign LED2 = led_q[1];
  assign LED3 = led_q[2];
  assign LED4 = led_q[3];
  assign MODE = mode;

endmodule

// File: tb/tb_led_mode_controller.sv
// tb/tb_led_mode_controller.sv - directed self-checking bench for led_mode_controller
module tb_led_mode_controller;

  logic       CLK;
  logic       RST;
  logic       SW;
  logic [3:0] BLINK_IN;
  logic       LED1;
  logic       LED2;
  logic       LED3;
  logic       LED4;
  logic [1:0] MODE;
  logic [3:0] leds;

  int checks   = 0;
  int failures = 0;

  led_mode_controller #(
    .DEBOUNCE_LIMIT(4),
    .PWM_BITS      (4),
    .DIM_DUTY      (3)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SW      (SW),
    .BLINK_IN(BLINK_IN),
    .LED1    (LED1),
    .LED2    (LED2),
    .LED3    (LED3),
    .LED4    (LED4),
    .MODE    (MODE)
  );

  assign leds = {LED4, LED3, LED2, LED1};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_button();
    @(negedge CLK) SW = 1'b1;
    repeat (12) @(posedge CLK);
    @(negedge CLK) SW = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_5hz();
    @(negedge CLK) BLINK_IN = 4'b0010;
    @(negedge CLK) BLINK_IN = 4'b0000;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int hi1;
    int hi2;
    int hi3;
    int hi4;
    logic [3:0] chase_exp [5];
    chase_exp[0] = 4'b0010;
    chase_exp[1] = 4'b0100;
    chase_exp[2] = 4'b1000;
    chase_exp[3] = 4'b0001;
    chase_exp[4] = 4'b0010;

    RST = 1'b1;
    SW = 1'b0;
    BLINK_IN = 4'b0000;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_mode", 32'(MODE), 32'd0);
    check("reset_leds", 32'(leds), 32'h0);

    // Pass-through with one cycle of latency
    @(negedge CLK) RST = 1'b0; BLINK_IN = 4'b1010;
    @(posedge CLK); #1;
    check("pass_1010", 32'(leds), 32'hA);
    check("pass_mode", 32'(MODE), 32'd0);
    @(negedge CLK) BLINK_IN = 4'b0101;
    @(posedge CLK); #1;
    check("pass_0101", 32'(leds), 32'h5);

    // Press timing: SW sampled high at edge k, MODE flips at k+7
    @(negedge CLK) BLINK_IN = 4'b1010; SW = 1'b1;
    repeat (7) @(posedge CLK); #1;
    check("press_k6_mode", 32'(MODE), 32'd0);
    @(posedge CLK); #1;
    check("press_k7_mode", 32'(MODE), 32'd1);
    repeat (50) @(posedge CLK); #1;
    check("hold_mode", 32'(MODE), 32'd1);
    check("all_leds", 32'(leds), 32'hF);
    @(negedge CLK) SW = 1'b0;
    repeat (20) @(posedge CLK); #1;
    check("release_mode", 32'(MODE), 32'd1);

    // Bounce shorter than the debounce limit
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK) SW = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK) SW = 1'b0;
      repeat (3) @(posedge CLK);
    end
    repeat (10) @(posedge CLK); #1;
    check("bounce_mode", 32'(MODE), 32'd1);
    check("bounce_leds", 32'(leds), 32'hF);

    // Chase with wrap
    @(negedge CLK) BLINK_IN = 4'b0000;
    press_button();
    check("chase_mode", 32'(MODE), 32'd2);
    check("chase_start", 32'(leds), 32'h1);
    for (int i = 0; i < 5; i++) begin
      pulse_5hz();
      check($sformatf("chase_step%0d", i), 32'(leds), 32'(chase_exp[i]));
    end

    // Dim: each LED high 3 of every 16 cycles
    press_button();
    check("dim_mode", 32'(MODE), 32'd3);
    hi1 = 0; hi2 = 0; hi3 = 0; hi4 = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      hi1 += int'(LED1);
      hi2 += int'(LED2);
      hi3 += int'(LED3);
      hi4 += int'(LED4);
    end
    check("dim_led1", 32'(hi1), 32'd3);
    check("dim_led2", 32'(hi2), 32'd3);
    check("dim_led3", 32'(hi3), 32'd3);
    check("dim_led4", 32'(hi4), 32'd3);
    press_button();
    check("wrap_mode", 32'(MODE), 32'd0);
    check("wrap_leds", 32'(leds), 32'h0);
    @(negedge CLK) BLINK_IN = 4'b1111;
    @(posedge CLK); #1;
    check("wrap_pass", 32'(leds), 32'hF);

    // Reset mid-chase and mid-debounce
    @(negedge CLK) BLINK_IN = 4'b0000;
    press_button();
    press_button();
    check("rst_pre_mode", 32'(MODE), 32'd2);
    pulse_5hz();
    pulse_5hz();
    check("rst_pre_pos2", 32'(leds), 32'h4);
    @(negedge CLK) SW = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK) RST = 1'b1; SW = 1'b0;
    @(posedge CLK); #1;
    check("rst_mode", 32'(MODE), 32'd0);
    check("rst_leds", 32'(leds), 32'h0);
    @(negedge CLK) RST = 1'b0; SW = 1'b1;
    repeat (7) @(posedge CLK); #1;
    check("fresh_k6_mode", 32'(MODE), 32'd0);
    @(posedge CLK); #1;
    check("fresh_k7_mode", 32'(MODE), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
